// File: rtl/decode_byte_queue.sv
// rtl/decode_byte_queue.sv - circular byte queue between instruction fetch and the x86 decoder
// Fetch pushes up to FETCH_BYTES per cycle; decoder sees the oldest WINDOW bytes and retires by length.
module decode_byte_queue #(
  parameter int DEPTH       = 32,
  parameter int FETCH_BYTES = 4,
  parameter int WINDOW      = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_flush,
  input  logic                             i_fetch_valid,
  output logic                             o_fetch_ready,
  input  logic [8*FETCH_BYTES-1:0]         i_fetch_data,
  input  logic [$clog2(FETCH_BYTES+1)-1:0] i_fetch_count,
  output logic                             o_window_valid,
  output logic [8*WINDOW-1:0]              o_window,
  output logic [$clog2(WINDOW+1)-1:0]      o_window_count,
  input  logic                             i_consume_valid,
  input  logic [4:0]                       i_consume_len,
  output logic                             o_consume_error,
  output logic [$clog2(DEPTH+1)-1:0]       o_level
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH+1);
  localparam int CW  = $clog2(WINDOW+1);
  localparam int FCW = $clog2(FETCH_BYTES+1);
  localparam int EW  = (CW > 5) ? CW : 5;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level;
  logic          consume_error;

  logic [CW-1:0]  window_count;
  logic           push_fire;
  logic [FCW-1:0] push_n;
  logic           consume_ok;
  logic [LW-1:0]  pop_n;

  // Everything below is a function of registered state; consume inputs never reach ready.
  assign window_count   = (level >= LW'(WINDOW)) ? CW'(WINDOW) : CW'(level);
  assign o_fetch_ready  = (LW'(DEPTH) - level) >= LW'(FETCH_BYTES);
  assign o_window_valid = (level != '0);
  assign o_window_count = window_count;
  assign o_level        = level;
  assign o_consume_error = consume_error;

  assign push_fire = i_fetch_valid && o_fetch_ready && !i_flush;
  assign push_n    = !push_fire ? '0 :
                     (i_fetch_count > FCW'(FETCH_BYTES)) ? FCW'(FETCH_BYTES) : i_fetch_count;

  // Legality uses the pre-cycle window, so same-cycle pushed bytes are never consumable.
  assign consume_ok = i_consume_valid && (i_consume_len != 5'd0) && (i_consume_len <= 5'd15) &&
                      (EW'(i_consume_len) <= EW'(window_count));
  assign pop_n      = (consume_ok && !i_flush) ? LW'(i_consume_len) : '0;

  always_comb begin
    o_window = '0;
    for (int k = 0; k < WINDOW; k++) begin
      if (CW'(k) < window_count)
        o_window[8*k +: 8] = mem[rd_ptr + PW'(k)];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < FETCH_BYTES; k++) begin
      if (k < int'(push_n))
        mem[wr_ptr + PW'(k)] <= i_fetch_data[8*k +: 8];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      consume_error <= 1'b0;
    end else if (i_flush) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      consume_error <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr + PW'(push_n);
      rd_ptr        <= rd_ptr + PW'(pop_n);
      level         <= level + LW'(push_n) - pop_n;
      consume_error <= i_consume_valid && !consume_ok;
    end
  end

endmodule

// File: tb/tb_decode_byte_queue.sv
// tb/tb_decode_byte_queue.sv - directed and randomized checks of decode_byte_queue against a byte-queue model
module tb_decode_byte_queue;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_flush;
  logic         i_fetch_valid;
  logic         o_fetch_ready;
  logic [31:0]  i_fetch_data;
  logic [2:0]   i_fetch_count;
  logic         o_window_valid;
  logic [127:0] o_window;
  logic [4:0]   o_window_count;
  logic         i_consume_valid;
  logic [4:0]   i_consume_len;
  logic         o_consume_error;
  logic [5:0]   o_level;

  decode_byte_queue dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready),
    .i_fetch_data(i_fetch_data), .i_fetch_count(i_fetch_count),
    .o_window_valid(o_window_valid), .o_window(o_window), .o_window_count(o_window_count),
    .i_consume_valid(i_consume_valid), .i_consume_len(i_consume_len),
    .o_consume_error(o_consume_error), .o_level(o_level)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  byte unsigned q[$];
  bit m_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [127:0] w;
    int cnt;
    w = '0;
    cnt = (q.size() < 16) ? q.size() : 16;
    for (int k = 0; k < cnt; k++) w[8*k +: 8] = q[k];
    check({tag, ".level"}, 128'(o_level), 128'(q.size()));
    check({tag, ".ready"}, 128'(o_fetch_ready), 128'((32 - q.size()) >= 4));
    check({tag, ".wvalid"}, 128'(o_window_valid), 128'(q.size() != 0));
    check({tag, ".wcount"}, 128'(o_window_count), 128'(cnt));
    check({tag, ".window"}, o_window, w);
    check({tag, ".err"}, 128'(o_consume_error), 128'(m_err));
  endtask

  // Called at a falling edge; applies inputs for one rising edge, then updates model and checks.
  task automatic step(input string tag, input bit fl, input bit fv, input logic [31:0] d,
                      input int cnt, input bit cv, input int len);
    bit ready, ok;
    int wc;
    i_flush = fl; i_fetch_valid = fv; i_fetch_data = d; i_fetch_count = 3'(cnt);
    i_consume_valid = cv; i_consume_len = 5'(len);
    ready = (32 - q.size()) >= 4;
    wc = (q.size() < 16) ? q.size() : 16;
    ok = cv && len >= 1 && len <= 15 && len <= wc;
    @(posedge i_clk);
    #1;
    if (fl) begin
      q.delete();
      m_err = 0;
    end else begin
      if (ok) for (int k = 0; k < len; k++) void'(q.pop_front());
      if (fv && ready) for (int k = 0; k < cnt; k++) q.push_back(d[8*k +: 8]);
      m_err = cv && !ok;
    end
    check_all(tag);
    @(negedge i_clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_flush = 0; i_fetch_valid = 0; i_fetch_data = 0; i_fetch_count = 0;
    i_consume_valid = 0; i_consume_len = 0;
    #2;
    check_all("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Basic push and consume
    step("push4", 0, 1, 32'h0001B866, 4, 0, 0);
    step("push2", 0, 1, 32'h00000000, 2, 0, 0);
    check("basic_window", o_window, 128'h0000_0000_0000_0000_0000_0001B866 & 128'hFFFF_FFFF_FFFF);
    step("consume6", 0, 0, 0, 0, 1, 6);
    check("consume6_level", 128'(o_level), 128'd0);

    // Fill, wrap and drain
    for (int i = 0; i < 8; i++)
      step("fill", 0, 1, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4, 0, 0);
    check("full_ready", 128'(o_fetch_ready), 128'd0);
    step("full_push_blocked", 0, 1, 32'hDEADBEEF, 4, 0, 0);
    step("consume5", 0, 0, 0, 0, 1, 5);
    step("push_wrap", 0, 1, 32'hA3A2A1A0, 4, 0, 0);
    step("consume15", 0, 0, 0, 0, 1, 15);
    step("consume12", 0, 0, 0, 0, 1, 12);
    check("wrap_byte0", 128'(o_window[7:0]), 128'h0A0);
    check("wrap_count", 128'(o_window_count), 128'd4);

    // Bad consumes: too long for level, zero, sixteen
    step("consume1", 0, 0, 0, 0, 1, 1);
    step("bad_len4", 0, 0, 0, 0, 1, 4);
    idle("err_clear");
    step("bad_len0", 0, 0, 0, 0, 1, 0);
    step("bad_len16", 0, 0, 0, 0, 1, 16);
    idle("err_clear2");

    // Simultaneous push and consume
    step("flush_a", 1, 0, 0, 0, 0, 0);
    step("to10_a", 0, 1, 32'h03020100, 4, 0, 0);
    step("to10_b", 0, 1, 32'h07060504, 4, 0, 0);
    step("to10_c", 0, 1, 32'h00000908, 2, 0, 0);
    step("push4_pop10", 0, 1, 32'h13121110, 4, 1, 10);
    step("refill", 0, 1, 32'h17161514, 4, 0, 0);
    step("refill2", 0, 1, 32'h00001918, 2, 0, 0);
    step("push4_pop12_bad", 0, 1, 32'h23222120, 4, 1, 12);
    check("simul_level", 128'(o_level), 128'd14);

    // Flush with concurrent push and consume
    step("flush_busy", 1, 1, 32'h33323130, 4, 1, 3);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 17));

    // Asynchronous reset between edges
    #2;
    i_rst_n = 1'b0;
    #1;
    q.delete();
    m_err = 0;
    check_all("async_reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step("post_reset_push", 0, 1, 32'h44434241, 3, 0, 0);
    for (int i = 0; i < 100; i++)
      step("rand2", 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 4),
           $urandom_range(0, 1), $urandom_range(1, 15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
